// File: rtl/vga_write_arbiter.sv
// Framebuffer write-port arbiter between the clear and draw engines: whole-operation grant,
// one-cycle start pulse, registered coordinate passthrough. Define RR_ARB_EN for round-robin arbitration.
module vga_write_arbiter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 11,
    parameter int YW    = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_req,
    input  logic          clr_done,
    input  logic [XW-1:0] clr_x,
    input  logic [YW-1:0] clr_y,
    output logic          clr_grant,
    output logic          clr_start,
    input  logic          drw_req,
    input  logic          drw_done,
    input  logic [XW-1:0] drw_x,
    input  logic [YW-1:0] drw_y,
    input  logic          drw_color,
    output logic          drw_grant,
    output logic          drw_start,
    output logic [XW-1:0] fb_x,
    output logic [YW-1:0] fb_y,
    output logic          fb_color,
    output logic          fb_we,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_OWN, S_RELEASE} state_t;

    localparam logic [XW-1:0] X_LIM = XW'(H_RES);
    localparam logic [YW-1:0] Y_LIM = YW'(V_RES);

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;      // 1 = draw engine; doubles as last owner
    logic          w_win_drw;
    logic          w_any_req;
    logic          w_own_done;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_color;
    logic          w_we;
    logic [XW-1:0] r_fb_x;
    logic [YW-1:0] r_fb_y;
    logic          r_fb_color;
    logic          r_fb_we;

    assign w_any_req  = clr_req | drw_req;
    assign w_own_done = r_owner ? drw_done  : clr_done;
    assign w_x        = r_owner ? drw_x     : clr_x;
    assign w_y        = r_owner ? drw_y     : clr_y;
    assign w_color    = r_owner ? drw_color : 1'b0;
    assign w_we       = ~w_own_done & (w_x < X_LIM) & (w_y < Y_LIM);

`ifdef RR_ARB_EN
    // on contention the client that did not own the port last time wins
    assign w_win_drw = drw_req & (~clr_req | ~r_owner);
`else
    assign w_win_drw = drw_req & ~clr_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_any_req)
                r_owner <= w_win_drw;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_next = S_START;
            S_START:   w_next = S_OWN;
            S_OWN:     if (w_own_done) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // grants and starts decode straight from state so reset clears them without a clock
    always_comb begin
        clr_grant = 1'b0;
        drw_grant = 1'b0;
        clr_start = 1'b0;
        drw_start = 1'b0;
        busy      = (r_state != S_IDLE);
        if (r_state == S_START || r_state == S_OWN) begin
            clr_grant = ~r_owner;
            drw_grant = r_owner;
        end
        if (r_state == S_START) begin
            clr_start = ~r_owner;
            drw_start = r_owner;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_fb_color <= 1'b0;
            r_fb_we    <= 1'b0;
        end else if (r_state == S_OWN) begin
            r_fb_x     <= w_x;
            r_fb_y     <= w_y;
            r_fb_color <= w_color;
            r_fb_we    <= w_we;
        end else begin
            r_fb_we    <= 1'b0;
        end
    end

    assign fb_x     = r_fb_x;
    assign fb_y     = r_fb_y;
    assign fb_color = r_fb_color;
    assign fb_we    = r_fb_we;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed + randomized bench for vga_write_arbiter; expectations come from an operation-level
// model of the grant timeline and pixel-visibility rules.
module tb_vga_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr_req = 0, clr_done = 0, drw_req = 0, drw_done = 0, drw_color = 0;
    logic [10:0] clr_x = 0, clr_y = 0, drw_x = 0, drw_y = 0;
    logic        clr_grant, clr_start, drw_grant, drw_start, fb_color, fb_we, busy;
    logic [10:0] fb_x, fb_y;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    bit last_drw = 1'b1;

    vga_write_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .clr_req(clr_req), .clr_done(clr_done), .clr_x(clr_x), .clr_y(clr_y),
        .clr_grant(clr_grant), .clr_start(clr_start),
        .drw_req(drw_req), .drw_done(drw_done), .drw_x(drw_x), .drw_y(drw_y),
        .drw_color(drw_color), .drw_grant(drw_grant), .drw_start(drw_start),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_we(fb_we), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input bit drw, input bit own_v, input bit other_v);
        if (drw) begin drw_done = own_v; clr_done = other_v; end
        else     begin clr_done = own_v; drw_done = other_v; end
    endtask

    // One whole operation, starting in an IDLE cycle and ending after RELEASE.
    task automatic do_op(input bit rc, input bit rd, input int nown, input bit sticky,
                         input bit hold_other, input bit sweep);
        bit drw;
        bit pwe = 0, pc = 0, dn, c;
        logic [10:0] px = 0, py = 0, x, y;
`ifdef RR_ARB_EN
        drw = rd && (!rc || !last_drw);
`else
        drw = rd && !rc;
`endif
        last_drw = drw;
        // IDLE: requests sampled here
        clr_req = rc; drw_req = rd;
        set_done(drw, sticky, 1'b0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_grant", {clr_grant, drw_grant}, 0);
        chk("idle_we", fb_we, 0);
        tick();
        // START
        clr_req = hold_other && drw; drw_req = hold_other && !drw;
        @(negedge clk);
        chk("start_grant", {clr_grant, drw_grant}, drw ? 2'b01 : 2'b10);
        chk("start_pulse", {clr_start, drw_start}, drw ? 2'b01 : 2'b10);
        chk("start_we", fb_we, 0);
        chk("start_busy", busy, 1);
        tick();
        // OWN
        for (int k = 0; k < nown; k++) begin
            dn = sticky || (k == nown - 1);
            if (sweep) begin
                x = 11'(630 + (k % 11)); y = 11'(470 + (k / 11));
            end else if (k == 0) begin
                x = 10; y = 20;
            end else begin
                x = (k % 4 == 1) ? 11'(639 + $urandom_range(0, 1)) : 11'($urandom_range(0, 700));
                y = (k % 4 == 2) ? 11'(479 + $urandom_range(0, 1)) : 11'($urandom_range(0, 520));
            end
            c = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            // the non-owner's coordinates, request and done are noise
            if (drw) begin
                drw_x = x; drw_y = y; drw_color = c;
                clr_x = 11'($urandom); clr_y = 11'($urandom);
                if (!hold_other) clr_req = 1'($urandom_range(0, 1));
            end else begin
                clr_x = x; clr_y = y;
                drw_x = 11'($urandom); drw_y = 11'($urandom); drw_color = 1'($urandom);
                if (!hold_other) drw_req = 1'($urandom_range(0, 1));
            end
            set_done(drw, dn, 1'($urandom_range(0, 1)));
            @(negedge clk);
            chk("own_grant", {clr_grant, drw_grant}, drw ? 2'b01 : 2'b10);
            chk("own_start", {clr_start, drw_start}, 0);
            chk("own_we", fb_we, pwe);
            if (pwe) begin
                chk("own_fbx", fb_x, px);
                chk("own_fby", fb_y, py);
                chk("own_color", fb_color, pc);
            end
            if (fb_we) writes++;
            pwe = !dn && x < 640 && y < 480;
            px = x; py = y; pc = drw ? c : 1'b0;
            tick();
        end
        // RELEASE
        set_done(drw, sticky, 1'b0);
        clr_req = hold_other && drw; drw_req = hold_other && !drw;
        @(negedge clk);
        chk("rel_grant", {clr_grant, drw_grant}, 0);
        chk("rel_start", {clr_start, drw_start}, 0);
        chk("rel_we", fb_we, 0);
        chk("rel_busy", busy, 1);
        tick();
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_out", {clr_grant, clr_start, drw_grant, drw_start, fb_color, fb_we, busy}, 0);
        chk("rst_fb", {fb_x, fb_y}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // single clear sweeping across the visible boundary: 10x10 visible pixels
        writes = 0;
        do_op(1, 0, 133, 0, 0, 1);
        chk("sweep_writes", writes, 100);

        // sticky done: START still issued, one OWN cycle, no writes
        writes = 0;
        clr_done = 1;
        do_op(1, 0, 1, 1, 0, 0);
        do_op(1, 0, 1, 1, 0, 0);
        chk("sticky_writes", writes, 0);
        clr_done = 0;

        // simultaneous requests, twice
        do_op(1, 1, 4, 0, 0, 0);
        do_op(1, 1, 4, 0, 0, 0);

        // draw passthrough with clr_req held through release; next IDLE shows no grant
        do_op(0, 1, 6, 0, 1, 0);
        do_op(1, 0, 3, 0, 0, 0);

        // randomized operations
        for (int i = 0; i < 20; i++) begin
            bit rc, rd;
            rc = 1'($urandom_range(0, 1));
            rd = rc ? 1'($urandom_range(0, 1)) : 1'b1;
            do_op(rc, rd, $urandom_range(2, 10), 0, 1'($urandom_range(0, 1)), 0);
        end
        clr_req = 0; drw_req = 0;

        // reset asserted between edges while clear is in OWN
        clr_req = 1; tick();
        clr_req = 0; tick();
        clr_x = 5; clr_y = 5;
        @(negedge clk);
        chk("pre_rst_grant", clr_grant, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {clr_grant, clr_start, drw_grant, drw_start, fb_color, fb_we, busy}, 0);
        chk("mid_rst_fb", {fb_x, fb_y}, 0);
        #1 reset_n = 1'b1;
        tick();
        last_drw = 1'b1;
        do_op(1, 1, 3, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
